// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the mem_bus request port between fetch (F) and load/store (D).
// Holds the bus fields for the whole transaction, inserts one idle cycle between requests and aborts stuck transfers.
module mem_bus_arbiter #(
  parameter int ADDR_W    = 18,
  parameter int TIMEOUT_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_start,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [2:0]        f_num_bytes,
  output logic              f_done,
  output logic [31:0]       f_rdata,
  input  logic              d_start,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_num_bytes,
  input  logic              d_is_write,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              err,
  output logic              bus_start,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [2:0]        bus_num_bytes,
  output logic              bus_is_write,
  output logic [31:0]       bus_wdata,
  input  logic              bus_done,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Watchdog fires on the busy cycle that would take it to all-ones.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_t               state, state_nxt;
  logic                 last_grant_d;
  logic                 gnt_d;
  logic [TIMEOUT_W-1:0] wdog;
  logic                 f_pend, d_pend;
  logic                 take_f, take_d;
  logic                 fin, fin_to;

  assign f_pend = f_start & ~f_done;
  assign d_pend = d_start & ~d_done;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take_f    = 1'b0;
    take_d    = 1'b0;
    fin       = 1'b0;
    fin_to    = 1'b0;
    case (state)
      IDLE: begin
        if (d_pend && (!f_pend || !last_grant_d)) begin
          take_d    = 1'b1;
          state_nxt = BUSY;
        end else if (f_pend) begin
          take_f    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (bus_done) begin
          fin       = 1'b1;
          state_nxt = RELEASE;
        end else if (wdog == WD_LAST) begin
          fin       = 1'b1;
          fin_to    = 1'b1;
          state_nxt = RELEASE;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_start     <= 1'b0;
      bus_addr      <= '0;
      bus_num_bytes <= '0;
      bus_is_write  <= 1'b0;
      bus_wdata     <= '0;
      f_done        <= 1'b0;
      d_done        <= 1'b0;
      f_rdata       <= '0;
      d_rdata       <= '0;
      err           <= 1'b0;
      last_grant_d  <= 1'b0;
      gnt_d         <= 1'b0;
      wdog          <= '0;
    end else begin
      if (take_f || take_d) begin
        bus_start     <= 1'b1;
        bus_addr      <= take_d ? d_addr : f_addr;
        bus_num_bytes <= take_d ? d_num_bytes : f_num_bytes;
        bus_is_write  <= take_d & d_is_write;
        bus_wdata     <= take_d ? d_wdata : '0;
        gnt_d         <= take_d;
        last_grant_d  <= take_d;
        wdog          <= '0;
      end
      if (state == BUSY && !fin) wdog <= wdog + WD_ONE;

      // Done flags follow their start; a completion this edge takes precedence.
      if (!f_start) f_done <= 1'b0;
      if (!d_start) d_done <= 1'b0;
      if (fin) begin
        bus_start <= 1'b0;
        err       <= fin_to;
        if (gnt_d) begin
          d_done  <= 1'b1;
          d_rdata <= fin_to ? '0 : bus_rdata;
        end else begin
          f_done  <= 1'b1;
          f_rdata <= fin_to ? '0 : bus_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction table, hand sequences for ties/reset/early drop,
// and a randomized run checked every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;
  localparam int ADDR_W    = 18;
  localparam int TIMEOUT_W = 4;
  localparam int WD_MAX    = (1 << TIMEOUT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              f_start = 1'b0, d_start = 1'b0, d_is_write = 1'b0;
  logic [ADDR_W-1:0] f_addr = '0, d_addr = '0;
  logic [2:0]        f_num_bytes = 3'd4, d_num_bytes = 3'd4;
  logic [31:0]       d_wdata = '0;
  logic              f_done, d_done, err, bus_start, bus_is_write;
  logic [31:0]       f_rdata, d_rdata, bus_wdata;
  logic [ADDR_W-1:0] bus_addr;
  logic [2:0]        bus_num_bytes;
  logic              bus_done = 1'b0;
  logic [31:0]       bus_rdata = '0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_W(TIMEOUT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_start(f_start), .f_addr(f_addr), .f_num_bytes(f_num_bytes),
    .f_done(f_done), .f_rdata(f_rdata),
    .d_start(d_start), .d_addr(d_addr), .d_num_bytes(d_num_bytes),
    .d_is_write(d_is_write), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .err(err),
    .bus_start(bus_start), .bus_addr(bus_addr), .bus_num_bytes(bus_num_bytes),
    .bus_is_write(bus_is_write), .bus_wdata(bus_wdata),
    .bus_done(bus_done), .bus_rdata(bus_rdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mem_bus responder: raises bus_done once bus_start has been seen high lat times; lat<0 never answers.
  int          resp_lat  = 0;
  logic [31:0] resp_data = '0;
  bit          rnd_mode  = 1'b0;
  int          rnd_lat   = 0;
  int          rcnt      = 0;
  initial begin
    forever begin
      int lat_now;
      tick();
      lat_now = rnd_mode ? rnd_lat : resp_lat;
      if (bus_start && !bus_done) begin
        if (lat_now >= 0 && rcnt >= lat_now) begin
          bus_done  = 1'b1;
          bus_rdata = rnd_mode ? $urandom : resp_data;
        end else begin
          rcnt++;
          bus_rdata = $urandom;
        end
      end else begin
        bus_done = 1'b0;
        if (!bus_start) begin
          rcnt    = 0;
          rnd_lat = $urandom_range(0, 8);
        end
      end
    end
  end

  // Transaction-level reference: who owns the bus, which fields were latched, and what each port sees.
  bit                m_busy = 0, m_own = 0, m_last = 0;
  int                m_gap = 0, m_cnt = 0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [2:0]        e_nb = '0;
  logic              e_w = 0, e_bs = 0, e_fd = 0, e_dd = 0, e_err = 0;
  logic [31:0]       e_wd = '0, e_frd = '0, e_drd = '0;
  bit                pf, pd, to;
  always begin
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0; m_own = 0; m_last = 0; m_gap = 0; m_cnt = 0;
      e_addr = '0; e_nb = '0; e_w = 0; e_wd = '0; e_bs = 0;
      e_fd = 0; e_dd = 0; e_frd = '0; e_drd = '0; e_err = 0;
    end else begin
      pf = f_start && !e_fd;
      pd = d_start && !e_dd;
      if (!f_start) e_fd = 0;
      if (!d_start) e_dd = 0;
      if (m_busy) begin
        if (bus_done || m_cnt + 1 == WD_MAX) begin
          to = !bus_done;
          m_busy = 0; m_gap = 1; e_bs = 0; e_err = to;
          if (m_own) begin e_dd = 1; e_drd = to ? 32'h0 : bus_rdata; end
          else       begin e_fd = 1; e_frd = to ? 32'h0 : bus_rdata; end
        end else begin
          m_cnt++;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (pf || pd) begin
        m_own  = pd && (!pf || !m_last);
        m_last = m_own;
        m_busy = 1; m_cnt = 0; e_bs = 1;
        e_addr = m_own ? d_addr : f_addr;
        e_nb   = m_own ? d_num_bytes : f_num_bytes;
        e_w    = m_own && d_is_write;
        e_wd   = d_wdata;
      end
    end
    #2;
    chk("m bus_start", bus_start, e_bs);
    chk("m bus_addr", bus_addr, e_addr);
    chk("m bus_num_bytes", bus_num_bytes, e_nb);
    chk("m bus_is_write", bus_is_write, e_w);
    if (m_busy && m_own) chk("m bus_wdata", bus_wdata, e_wd);
    chk("m f_done", f_done, e_fd);
    chk("m d_done", d_done, e_dd);
    chk("m f_rdata", f_rdata, e_frd);
    chk("m d_rdata", d_rdata, e_drd);
    chk("m err", err, e_err);
  end

  typedef struct {
    bit                is_d;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        nb;
    bit                w;
    logic [31:0]       wd;
    int                lat;
    logic [31:0]       rd;
    int                exp_hi;
    logic [31:0]       exp_rd;
    bit                exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int hi, n, gap;
    bit seen, saw_w, ok;
    logic [ADDR_W-1:0] first_addr;
    logic [31:0] first_wd;
    bit order[4];

    tbl[0] = '{0, 18'h00010, 3'd4, 0, 32'h0,        5, 32'hDEADBEEF, 6,  32'hDEADBEEF, 0};
    tbl[1] = '{1, 18'h20005, 3'd1, 1, 32'h00000001, 3, 32'h12345678, 4,  32'h12345678, 0};
    tbl[2] = '{1, 18'h3FFFF, 3'd2, 0, 32'h0,        0, 32'hCAFEF00D, 1,  32'hCAFEF00D, 0};
    tbl[3] = '{0, 18'h1ABCD, 3'd4, 0, 32'h0,       -1, 32'h55555555, 15, 32'h0,        1};
    tbl[4] = '{1, 18'h00100, 3'd4, 0, 32'h0,       14, 32'hA5A5A5A5, 15, 32'hA5A5A5A5, 0};
    tbl[5] = '{0, 18'h00020, 3'd3, 0, 32'h0,        1, 32'h0BADF00D, 2,  32'h0BADF00D, 0};

    // Reset values
    repeat (3) tick();
    chk("reset bus_start", bus_start, 0);
    chk("reset err", err, 0);
    rst_n = 1'b1;
    tick();

    // Table of single transactions
    for (int i = 0; i < 6; i++) begin
      resp_lat = tbl[i].lat; resp_data = tbl[i].rd;
      if (tbl[i].is_d) begin
        d_addr = tbl[i].addr; d_num_bytes = tbl[i].nb; d_is_write = tbl[i].w;
        d_wdata = tbl[i].wd; d_start = 1'b1;
      end else begin
        f_addr = tbl[i].addr; f_num_bytes = tbl[i].nb; f_start = 1'b1;
      end
      hi = 0; seen = 0; saw_w = 0; ok = 0; first_addr = '0; first_wd = '0;
      for (int c = 0; c < 40; c++) begin
        tick();
        if (bus_start) begin
          if (!seen) begin first_addr = bus_addr; first_wd = bus_wdata; end
          seen = 1; hi++; saw_w |= bus_is_write;
          if (bus_addr != first_addr || bus_wdata != first_wd) chk("tbl stable", bus_addr, first_addr);
        end
        if ((tbl[i].is_d ? d_done : f_done)) begin ok = 1; break; end
      end
      chk($sformatf("tbl%0d done seen", i), ok, 1);
      chk($sformatf("tbl%0d start cycles", i), hi, tbl[i].exp_hi);
      chk($sformatf("tbl%0d addr", i), first_addr, tbl[i].addr);
      chk($sformatf("tbl%0d is_write", i), saw_w, tbl[i].is_d && tbl[i].w);
      if (tbl[i].w) chk($sformatf("tbl%0d wdata", i), first_wd, tbl[i].wd);
      chk($sformatf("tbl%0d rdata", i), tbl[i].is_d ? d_rdata : f_rdata, tbl[i].exp_rd);
      chk($sformatf("tbl%0d err", i), err, tbl[i].exp_err);
      repeat (2) tick();
      chk($sformatf("tbl%0d done hold", i), tbl[i].is_d ? d_done : f_done, 1);
      f_start = 1'b0; d_start = 1'b0; d_is_write = 1'b0;
      tick();
      chk($sformatf("tbl%0d done clear", i), tbl[i].is_d ? d_done : f_done, 0);
      tick();
    end

    // Tie from reset: grants must alternate D,F,D,F
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    resp_lat = 2; resp_data = 32'h11112222;
    f_addr = 18'h00111; d_addr = 18'h00222; d_is_write = 1'b0;
    f_start = 1'b1; d_start = 1'b1;
    n = 0; seen = 0;
    for (int c = 0; c < 200 && n < 4; c++) begin
      tick();
      if (bus_start && !seen) begin order[n] = (bus_addr == 18'h00222); n++; end
      seen = bus_start;
      if (f_start && f_done) f_start = 1'b0; else if (!f_start && !f_done) f_start = 1'b1;
      if (d_start && d_done) d_start = 1'b0; else if (!d_start && !d_done) d_start = 1'b1;
    end
    chk("tie grant count", n, 4);
    chk("tie grant0 D", order[0], 1);
    chk("tie grant1 F", order[1], 0);
    chk("tie grant2 D", order[2], 1);
    chk("tie grant3 F", order[3], 0);
    f_start = 1'b0; d_start = 1'b0;
    repeat (10) tick();

    // Reset in the middle of a transaction
    resp_lat = -1; f_addr = 18'h00444; f_start = 1'b1;
    repeat (4) tick();
    chk("rst pre bus_start", bus_start, 1);
    rst_n = 1'b0;
    tick();
    chk("rst bus_start", bus_start, 0);
    chk("rst f_done", f_done, 0);
    chk("rst d_done", d_done, 0);
    rst_n = 1'b1; resp_lat = 2; resp_data = 32'h600DCAFE;
    ok = 0;
    for (int c = 0; c < 20; c++) begin tick(); if (f_done) begin ok = 1; break; end end
    chk("rst regrant done", ok, 1);
    chk("rst regrant rdata", f_rdata, 32'h600DCAFE);
    f_start = 1'b0;
    repeat (3) tick();

    // Early drop of f_start while busy, with D waiting
    resp_lat = 4; resp_data = 32'h77778888; f_addr = 18'h00777; f_start = 1'b1;
    ok = 0;
    for (int c = 0; c < 10; c++) begin tick(); if (bus_start) begin ok = 1; break; end end
    chk("drop grant F", ok, 1);
    d_addr = 18'h00888; d_is_write = 1'b0; d_start = 1'b1; f_start = 1'b0;
    ok = 0;
    for (int c = 0; c < 20; c++) begin tick(); if (f_done) begin ok = 1; break; end end
    chk("drop f_done pulse", ok, 1);
    chk("drop f_rdata", f_rdata, 32'h77778888);
    tick();
    chk("drop f_done clears", f_done, 0);
    gap = 1;
    while (!bus_start && gap < 10) begin tick(); gap++; end
    chk("drop gap to D grant", gap, 2);
    chk("drop D addr", bus_addr, 18'h00888);
    ok = 0;
    for (int c = 0; c < 20; c++) begin tick(); if (d_done) begin ok = 1; break; end end
    chk("drop d_done", ok, 1);
    d_start = 1'b0;
    repeat (3) tick();

    // Randomized traffic, checked by the reference model every cycle
    rnd_mode = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (!f_start) begin
        if (!f_done && !(m_busy && !m_own) && $urandom_range(0, 2) == 0) begin
          f_start = 1'b1; f_addr = ADDR_W'($urandom); f_num_bytes = 3'($urandom_range(1, 4));
        end
      end else if (f_done) begin
        if ($urandom_range(0, 1) == 0) f_start = 1'b0;
      end else if (m_busy && !m_own) begin
        if ($urandom_range(0, 9) == 0) f_start = 1'b0;
        else if ($urandom_range(0, 3) == 0) f_addr = ADDR_W'($urandom);
      end
      if (!d_start) begin
        if (!d_done && !(m_busy && m_own) && $urandom_range(0, 2) == 0) begin
          d_start = 1'b1; d_addr = ADDR_W'($urandom); d_num_bytes = 3'($urandom_range(1, 4));
          d_is_write = 1'($urandom); d_wdata = $urandom;
        end
      end else if (d_done) begin
        if ($urandom_range(0, 1) == 0) d_start = 1'b0;
      end else if (m_busy && m_own) begin
        if ($urandom_range(0, 9) == 0) d_start = 1'b0;
        else if ($urandom_range(0, 3) == 0) d_wdata = $urandom;
      end
      if (c == 1000) begin
        rst_n = 1'b0; tick(); rst_n = 1'b1;
      end
    end
    f_start = 1'b0; d_start = 1'b0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
